multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through the FETCH, DECODE, EXEC, MEM and WB phases.
- Drives the handshakes to instruction and data memory, with a ready timeout.
- Configures the datapath: sext op, ALU op and operand selects, register-file write, PC update.
- Traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- TIMEOUT, 255: max cycles a memory request may wait for ready before a trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  instruction register contents; valid from DECODE until the next FETCH
- imem_rdy  in  1  instruction memory ready; inst is captured on the same edge
- dmem_rdy  in  1  data memory ready
- br_true  in  1  branch comparison result from the ALU; valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register write strobe
- pc_we  out  1  PC write strobe
- npc_sel  out  2  next-PC source: 0 = pc+4, 1 = pc+imm, 2 = ALU result with bit0 cleared
- sext_op  out  3  immediate format: 0 = I, 1 = shamt, 2 = B, 3 = S, 4 = U, 5 = J
- alu_op  out  4  ALU operation
- alu_a_sel  out  1  ALU operand A: 0 = rs1, 1 = pc
- alu_b_sel  out  1  ALU operand B: 0 = rs2, 1 = imm
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- rf_we  out  1  register-file write enable
- wb_sel  out  2  write-back source: 0 = ALU, 1 = mem, 2 = pc+4, 3 = imm
- trap  out  1  sticky trap flag
- trap_cause  out  2  trap reason: 0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout
- state  out  3  current FSM state (debug)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - While rst_n = 0, asynchronously: state = FETCH, trap = 0, trap_cause = 0, instret = 0, timeout counter = 0.
  - All strobes (imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we) are 0 in reset.
  - Reset during any phase aborts the instruction immediately with no PC or RF write.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7. Codes 5 and 6 go to TRAP with cause 1.
- Decode outputs:
  - sext_op, alu_op, alu_a_sel, alu_b_sel, wb_sel and npc_sel are combinational from inst[6:0], funct3 and inst[30].
  - They are stable from DECODE through WB because the IR is written only in FETCH.
- Opcode mapping:
  - 0110011 (R-type): alu_op = {inst[30], funct3}, b = rs2, wb = ALU.
  - 0010011 (I-type ALU): funct3 001/101 use sext 1, others sext 0. alu_op = {inst[30] & (funct3 == 101), funct3}. b = imm, wb = ALU.
  - 0000011 (load): sext 0, alu_op = 0000 (add), b = imm, wb = mem.
  - 0100011 (store): sext 3, alu_op = 0000 (add), b = imm.
  - 1100011 (branch): sext 2, alu_op = {1, funct3}, b = rs2.
  - 0110111 (lui): sext 4, wb = imm.
  - 0010111 (auipc): sext 4, a = pc, b = imm, alu_op = 0000 (add), wb = ALU.
  - 1101111 (jal): sext 5, wb = pc+4, npc_sel = 1.
  - 1100111 (jalr): sext 0, a = rs1, b = imm, alu_op = 0000 (add), wb = pc+4, npc_sel = 2.
  - Any other opcode is illegal. sext_op = 0 and alu_op = 0 for illegal opcodes.
- FETCH:
  - imem_req = 1.
  - On imem_rdy = 1: ir_we = 1 that cycle, next state DECODE.
- DECODE:
  - Legal opcode: next state EXEC.
  - Illegal opcode: next state TRAP with cause 1.
- EXEC:
  - Branch: pc_we = 1, npc_sel = br_true ? 1 : 0, next state FETCH.
  - Load or store: next state MEM.
  - All others: next state WB.
- MEM:
  - dmem_req = 1 is held; dmem_we = 1 for stores.
  - On dmem_rdy with a store: pc_we = 1, npc_sel = 0, next state FETCH.
  - On dmem_rdy with a load: next state WB.
- WB:
  - rf_we = 1 if inst[11:7] != 0.
  - pc_we = 1 with npc_sel per the opcode mapping (0 when the mapping does not specify it).
  - Next state FETCH.
- Retire:
  - instret increments by 1 on every cycle with pc_we = 1.
  - instret wraps modulo 2^CNT_W.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle while a request is held without ready.
  - If it reaches TIMEOUT, next state is TRAP with cause 2 (FETCH) or 3 (MEM).
  - Ready arriving on the same cycle the count reaches TIMEOUT wins: the normal transition is taken.
- TRAP:
  - All strobes are 0; trap = 1 and trap_cause are held.
  - The FSM leaves TRAP only through reset.
- Strobe exclusivity: at most one of ir_we, rf_we and dmem_req is high in any cycle.

Test Plan:
- addi x1,x0,5 (0x00500093) with imem_rdy = 1 the first cycle:
  - States FETCH, DECODE, EXEC, WB.
  - sext_op = 0 and alu_b_sel = 1.
  - rf_we = 1 and pc_we = 1 in WB with npc_sel = 0.
  - instret = 1.
- beq taken (0x00000463, br_true = 1): pc_we = 1 in EXEC with npc_sel = 1 and sext_op = 2, rf_we never asserted.
- beq not taken (same encoding, br_true = 0): pc_we = 1 in EXEC with npc_sel = 0.
- sw (0x00112223) with dmem_rdy delayed 3 cycles:
  - dmem_req and dmem_we are held 4 cycles and sext_op = 3.
  - Return to FETCH, instret +1.
- lw (0x00002083) with dmem_rdy delayed 1 cycle: dmem_req = 1 and dmem_we = 0 for 2 cycles in MEM, then WB with rf_we = 1 and wb_sel = 1.
- jal x1,+8 (0x008000EF): sext_op = 5, WB asserts rf_we with wb_sel = 2 and pc_we with npc_sel = 1.
- Opcode 0x0000007F: TRAP after DECODE with trap_cause = 1, no further imem_req; rst_n low then returns to FETCH with instret = 0.
- imem_rdy held 0 with TIMEOUT = 4: trap_cause = 2 after 4 wait cycles.
- Repeat with imem_rdy rising on the 4th wait cycle: DECODE, no trap.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshakes with a ready timeout, datapath decode, trap and retire counting.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    input  logic             br_true,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic [2:0]       sext_op,
    output logic [3:0]       alu_op,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    logic [6:0]    opc;
    logic [2:0]    f3;
    logic          is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr, legal;
    logic [1:0]    dec_npc;
    logic [2:0]    nstate;
    logic [1:0]    ncause;
    logic          wait_cyc;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;

    assign opc      = inst[6:0];
    assign f3       = inst[14:12];
    assign is_r     = (opc == 7'b0110011);
    assign is_i     = (opc == 7'b0010011);
    assign is_ld    = (opc == 7'b0000011);
    assign is_st    = (opc == 7'b0100011);
    assign is_br    = (opc == 7'b1100011);
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign is_jal   = (opc == 7'b1101111);
    assign is_jalr  = (opc == 7'b1100111);
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;
    assign tcnt_inc = tcnt + 1'b1;

    // Datapath configuration depends only on the IR, so it stays stable DECODE..WB.
    always_comb begin
        sext_op   = 3'd0;
        alu_op    = 4'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        wb_sel    = 2'd0;
        dec_npc   = 2'd0;
        if (is_r) begin
            alu_op = {inst[30], f3};
        end else if (is_i) begin
            sext_op   = ((f3 == 3'b001) || (f3 == 3'b101)) ? 3'd1 : 3'd0;
            alu_op    = {inst[30] & (f3 == 3'b101), f3};
            alu_b_sel = 1'b1;
        end else if (is_ld) begin
            alu_b_sel = 1'b1;
            wb_sel    = 2'd1;
        end else if (is_st) begin
            sext_op   = 3'd3;
            alu_b_sel = 1'b1;
        end else if (is_br) begin
            sext_op = 3'd2;
            alu_op  = {1'b1, f3};
        end else if (is_lui) begin
            sext_op = 3'd4;
            wb_sel  = 2'd3;
        end else if (is_auipc) begin
            sext_op   = 3'd4;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
        end else if (is_jal) begin
            sext_op = 3'd5;
            wb_sel  = 2'd2;
            dec_npc = 2'd1;
        end else if (is_jalr) begin
            alu_b_sel = 1'b1;
            wb_sel    = 2'd2;
            dec_npc   = 2'd2;
        end
    end

    always_comb begin
        nstate   = state;
        ncause   = trap_cause;
        wait_cyc = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_rdy) begin
                    nstate = S_DECODE;
                end else begin
                    wait_cyc = 1'b1;
                    if (tcnt_inc == TLIM) begin
                        nstate = S_TRAP;
                        ncause = 2'd2;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    nstate = S_EXEC;
                end else begin
                    nstate = S_TRAP;
                    ncause = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_br)               nstate = S_FETCH;
                else if (is_ld || is_st) nstate = S_MEM;
                else                     nstate = S_WB;
            end
            S_MEM: begin
                if (dmem_rdy) begin
                    nstate = is_st ? S_FETCH : S_WB;
                end else begin
                    wait_cyc = 1'b1;
                    if (tcnt_inc == TLIM) begin
                        nstate = S_TRAP;
                        ncause = 2'd3;
                    end
                end
            end
            S_WB:    nstate = S_FETCH;
            S_TRAP:  nstate = S_TRAP;
            default: begin
                nstate = S_TRAP;
                ncause = 2'd1;
            end
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset is held, even though state reads FETCH.
    always_comb begin
        imem_req = rst_n && (state == S_FETCH);
        ir_we    = rst_n && (state == S_FETCH) && imem_rdy;
        dmem_req = rst_n && (state == S_MEM);
        dmem_we  = rst_n && (state == S_MEM) && is_st;
        rf_we    = rst_n && (state == S_WB) && (inst[11:7] != 5'd0);
        pc_we    = rst_n && (((state == S_EXEC) && is_br) ||
                             ((state == S_MEM) && is_st && dmem_rdy) ||
                             (state == S_WB));
        npc_sel  = dec_npc;
        if ((state == S_EXEC) && is_br)
            npc_sel = {1'b0, br_true};
        else if (state == S_MEM)
            npc_sel = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            instret    <= '0;
            tcnt       <= '0;
        end else begin
            state <= nstate;
            tcnt  <= wait_cyc ? tcnt_inc : '0;
            if ((nstate == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= ncause;
            end
            if (pc_we)
                instret <= instret + 1'b1;
        end
    end

endmodule
